// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN image loader: frame geometry, prediction
// width and the loader state encoding.
package cnn_pkg;

  localparam int PIX_W  = 8;
  localparam int N_PIX  = 144;
  localparam int IMG_W  = PIX_W * N_PIX;
  localparam int PRED_W = 32;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_img_loader_pack.sv
// Indexed pixel register bank: one PIX_W-bit lane per pixel, written by index.
// The assembled lanes form the packed image vector handed to the network.
module cnn_img_loader_pack #(
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int N_PIX = cnn_pkg::N_PIX,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [PIX_W-1:0]         data,
  output logic [PIX_W*N_PIX-1:0]   img
);

  // Write the addressed pixel lane; all other lanes hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img <= '0;
    end else if (we) begin
      img[PIX_W*idx +: PIX_W] <= data;
    end
  end

endmodule

// File: rtl/cnn_img_loader.sv
// Upstream feeder for top_cnn. Packs a frame of pixels into one wide vector,
// presents it to the network, waits for a fresh ready and returns the
// captured prediction as a one-cycle strobe. One frame buffer, no overlap.
module cnn_img_loader
  import cnn_pkg::*;
#(
  parameter  int PIX_W   = cnn_pkg::PIX_W,
  parameter  int N_PIX   = cnn_pkg::N_PIX,
  parameter  int TIMEOUT = 65535,
  localparam int IMG_W   = PIX_W * N_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic [IMG_W-1:0]  img_out,
  output logic              img_valid,
  input  logic              cnn_ready,
  input  logic [PRED_W-1:0] cnn_predict,
  output logic              result_valid,
  output logic [PRED_W-1:0] result_number,
  output logic [15:0]       frame_cnt,
  output logic              err_timeout
);

  localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   pix_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               accept;
  logic               last_pix;
  logic               go_done;
  logic               armed;
  logic [CNT_W-1:0]   wait_cnt;

  // A start-of-frame pixel always lands at index 0, resyncing a partial frame.
  assign accept   = pix_valid & pix_ready;
  assign wr_idx   = pix_sof ? '0 : pix_idx;
  assign last_pix = (wr_idx == IDX_W'(N_PIX - 1));
  // Ready only counts once it has been seen low during this WAIT, so a ready
  // left high from the previous frame cannot complete the new one.
  assign go_done  = (state == WAIT) & armed & cnn_ready;

  cnn_img_loader_pack #(
    .PIX_W (PIX_W),
    .N_PIX (N_PIX),
    .IDX_W (IDX_W)
  ) u_pack (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .idx  (wr_idx),
    .data (pix_data),
    .img  (img_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fill the frame, wait for a qualified ready, report once.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && last_pix) state_nxt = WAIT;
      WAIT:    if (go_done)            state_nxt = DONE;
      DONE:                            state_nxt = FILL;
      default:                         state_nxt = FILL;
    endcase
  end

  // Outputs decoded from state; pix_ready is held low while reset is asserted.
  always_comb begin
    pix_ready    = 1'b0;
    img_valid    = 1'b0;
    result_valid = 1'b0;
    case (state)
      FILL:    pix_ready    = ~rst;
      WAIT:    img_valid    = 1'b1;
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // Pixel write pointer: advances per accepted pixel, rewinds after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_idx <= '0;
    end else if (state == FILL && accept) begin
      pix_idx <= last_pix ? '0 : wr_idx + 1'b1;
    end
  end

  // Ready qualification and WAIT watchdog; both clear when the frame retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (state == WAIT) begin
      if (!cnn_ready) armed <= 1'b1;
      if (wait_cnt != CNT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == CNT_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
    end else if (state == DONE) begin
      armed    <= 1'b0;
      wait_cnt <= '0;
    end
  end

  // Capture the prediction and count the frame on the edge that enters DONE,
  // so both are already valid while result_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_number <= '0;
      frame_cnt     <= '0;
    end else if (go_done) begin
      result_number <= cnn_predict;
      frame_cnt     <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cnn_img_loader.sv
// Scoreboard bench for cnn_img_loader: pixel packing, ready qualification,
// resync, back-pressure, asynchronous reset and the WAIT timeout.
module tb_cnn_img_loader;

  localparam int PW = 8;
  localparam int NP = 144;
  localparam int VW = PW * NP;
  localparam int TO = 10;

  typedef logic [VW-1:0] vt;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          pix_sof;
  logic [PW-1:0] pix_data;
  logic          pix_ready;
  logic [VW-1:0] img_out;
  logic          img_valid;
  logic          cnn_ready;
  logic [31:0]   cnn_predict;
  logic          result_valid;
  logic [31:0]   result_number;
  logic [15:0]   frame_cnt;
  logic          err_timeout;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    mimg [NP];
  int            midx;
  int            exp_frames;
  logic [31:0]   sb_q [$];
  int            res_cnt = 0;
  logic          rv_prev = 1'b0;

  always #5 clk = ~clk;

  cnn_img_loader #(
    .PIX_W   (PW),
    .N_PIX   (NP),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .img_out       (img_out),
    .img_valid     (img_valid),
    .cnn_ready     (cnn_ready),
    .cnn_predict   (cnn_predict),
    .result_valid  (result_valid),
    .result_number (result_number),
    .frame_cnt     (frame_cnt),
    .err_timeout   (err_timeout)
  );

  task automatic check(input string tag, input vt act, input vt exp);
    int fb;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      fb = -1;
      for (int i = NP - 1; i >= 0; i--)
        if (act[PW*i +: PW] !== exp[PW*i +: PW]) fb = i;
      $display("FAIL %s: got %0h want %0h (first differing byte %0d)",
               tag, act[63:0], exp[63:0], fb);
    end
  endtask

  function automatic vt model_img();
    vt v;
    for (int i = 0; i < NP; i++) v[PW*i +: PW] = mimg[i];
    return v;
  endfunction

  task automatic send_pix(input logic [7:0] d, input logic s);
    int   guard;
    int   idx;
    logic rdy;
    guard     = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = s;
    do begin
      @(negedge clk);
      rdy = pix_ready;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) begin
      check("pix_accept_timeout", vt'(rdy), vt'(1));
    end else begin
      idx       = s ? 0 : midx;
      mimg[idx] = d;
      midx      = (idx + 1 == NP) ? 0 : idx + 1;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] off, input logic hold_ready);
    cnn_ready = hold_ready;
    for (int k = 0; k < NP; k++) begin
      if (k == NP - 1) check("img_valid_pre", vt'(img_valid), vt'(0));
      send_pix(8'(k) + off, k == 0);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    check("img_valid_rise", vt'(img_valid), vt'(1));
    check("pix_ready_wait", vt'(pix_ready), vt'(0));
    check("img_out", img_out, model_img());
  endtask

  task automatic finish_frame(input logic [31:0] p, input int low_n);
    cnn_predict = p;
    sb_q.push_back(p);
    cnn_ready = 1'b0;
    repeat (low_n) @(posedge clk);
    #1;
    cnn_ready = 1'b1;
    @(posedge clk);
    #1;
    check("res_latency", vt'(result_valid), vt'(1));
    if (result_valid) begin
      exp_frames++;
      check("frame_cnt", vt'(frame_cnt), vt'(exp_frames));
      check("img_valid_done", vt'(img_valid), vt'(0));
      cnn_ready = 1'b0;
      @(posedge clk);
      #1;
      check("res_single", vt'(result_valid), vt'(0));
      check("pix_ready_back", vt'(pix_ready), vt'(1));
    end
    cnn_ready = 1'b0;
  endtask

  // Result monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev <= 1'b0;
    end else begin
      rv_prev <= result_valid;
      if (result_valid) begin
        res_cnt <= res_cnt + 1;
        check("res_double", vt'(rv_prev), vt'(0));
        if (sb_q.size() == 0) check("res_unexpected", vt'(result_valid), vt'(0));
        else check("res_number", vt'(result_number), vt'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_sof     = 1'b0;
    pix_data    = '0;
    cnn_ready   = 1'b0;
    cnn_predict = '0;
    midx        = 0;
    exp_frames  = 0;
    for (int i = 0; i < NP; i++) mimg[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_img_valid", vt'(img_valid), vt'(0));
    check("rst_pix_ready", vt'(pix_ready), vt'(0));
    check("rst_result_valid", vt'(result_valid), vt'(0));
    check("rst_result_number", vt'(result_number), vt'(0));
    check("rst_frame_cnt", vt'(frame_cnt), vt'(0));
    check("rst_err", vt'(err_timeout), vt'(0));
    check("rst_img_out", img_out, vt'(0));
    rst = 1'b0;
    #1;
    check("pix_ready_first", vt'(pix_ready), vt'(1));

    // Basic frame: byte k == k, ready low for 5 cycles, predict 7
    send_frame(8'h00, 1'b0);
    check("byte0", vt'(img_out[7:0]), vt'(8'h00));
    check("byte100", vt'(img_out[807:800]), vt'(8'd100));
    check("byte143", vt'(img_out[1151:1144]), vt'(8'd143));
    finish_frame(32'd7, 5);
    check("no_err_basic", vt'(err_timeout), vt'(0));

    // Stale ready held high across the frame end
    send_frame(8'h40, 1'b1);
    r0 = res_cnt;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("stale_no_done", vt'(result_valid), vt'(0));
      check("stale_img_valid", vt'(img_valid), vt'(1));
    end
    finish_frame(32'h1234_5678, 1);
    repeat (3) @(posedge clk);
    #1;
    check("stale_one_result", vt'(res_cnt - r0), vt'(1));

    // Mid-frame resync: 50 stale pixels then a fresh sof frame
    send_pix(8'hAA, 1'b1);
    for (int k = 1; k < 50; k++) send_pix(8'hAA, 1'b0);
    send_frame(8'h11, 1'b0);
    check("resync_byte0", vt'(img_out[7:0]), vt'(8'h11));
    check("resync_byte60", vt'(img_out[487:480]), vt'(8'h11 + 8'd60));
    finish_frame(32'hDEAD_BEEF, 2);

    // Back-pressure: a pixel offered during WAIT must not be consumed
    send_frame(8'h80, 1'b0);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 8'h55;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("bp_pix_ready", vt'(pix_ready), vt'(0));
      check("bp_img_frozen", img_out, model_img());
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    finish_frame(32'd99, 1);
    send_frame(8'h30, 1'b0);
    finish_frame(32'd5, 2);

    // Asynchronous reset in WAIT, between clock edges
    send_frame(8'h20, 1'b0);
    cnn_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_img_valid", vt'(img_valid), vt'(0));
    check("arst_pix_ready", vt'(pix_ready), vt'(0));
    check("arst_frame_cnt", vt'(frame_cnt), vt'(0));
    check("arst_result_valid", vt'(result_valid), vt'(0));
    check("arst_img_out", img_out, vt'(0));
    check("arst_result_number", vt'(result_number), vt'(0));
    exp_frames = 0;
    midx       = 0;
    for (int i = 0; i < NP; i++) mimg[i] = '0;
    cnn_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_fill", vt'(pix_ready), vt'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
      check("arst_no_result", vt'(result_valid), vt'(0));
      check("arst_stays_fill", vt'(img_valid), vt'(0));
    end
    cnn_ready = 1'b0;
    send_frame(8'h60, 1'b0);
    finish_frame(32'h42, 1);

    // Timeout: ready never rises
    send_frame(8'h90, 1'b0);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_not_yet", vt'(err_timeout), vt'(0));
    @(posedge clk);
    #1;
    check("to_raised", vt'(err_timeout), vt'(1));
    repeat (5) @(posedge clk);
    #1;
    check("to_sticky", vt'(err_timeout), vt'(1));
    check("to_still_wait", vt'(img_valid), vt'(1));
    check("to_pix_ready", vt'(pix_ready), vt'(0));
    #2;
    rst = 1'b1;
    #1;
    check("to_cleared", vt'(err_timeout), vt'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("to_back_fill", vt'(pix_ready), vt'(1));

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", vt'(sb_q.size()), vt'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
